// File: rtl/sf_tester_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module   : sf_tester_pattern_seq
// Brief    : Page-by-page flash test sequencer.  Generates or checks an
//            arithmetic byte pattern over one iteration slice of the device.
// Options  : SF_TESTER_ERR_ADDR_CAPTURE_EN - capture first mismatch address
// Revision : 1.0 - initial release
// ============================================================================
module sf_tester_pattern_seq #(
   parameter int PARM_TOTAL_BYTES = 33554432,
   parameter int PARM_ITER_COUNT  = 32,
   parameter int PARM_PAGE_BYTES  = 256,
   parameter int PARM_ERR_WIDTH   = 16
) (
   input  logic                               i_clk_20mhz,
   input  logic                               i_rst_20mhz,
   input  logic                               i_start,
   input  logic                               i_abort,
   input  logic                               i_mode,
   input  logic [$clog2(PARM_ITER_COUNT)-1:0] i_iter_sel,
   input  logic [7:0]                         i_pat_start,
   input  logic [7:0]                         i_pat_incr,
   output logic                               o_page_req,
   output logic [31:0]                        o_page_addr,
   output logic [7:0]                         o_wr_byte,
   output logic                               o_wr_valid,
   input  logic                               i_wr_ready,
   input  logic [7:0]                         i_rd_byte,
   input  logic                               i_rd_valid,
   input  logic                               i_page_done,
   output logic                               o_busy,
   output logic                               o_done,
   output logic                               o_pass,
   output logic [PARM_ERR_WIDTH-1:0]          o_err_count,
   output logic [31:0]                        o_err_addr
);

   localparam int c_iter_bytes = PARM_TOTAL_BYTES / PARM_ITER_COUNT;
   localparam int c_pages      = c_iter_bytes / PARM_PAGE_BYTES;
   localparam int c_bcnt_w     = (PARM_PAGE_BYTES > 1) ? $clog2(PARM_PAGE_BYTES) : 1;
   localparam int c_pcnt_w     = (c_pages > 1) ? $clog2(c_pages) : 1;

   localparam logic [c_bcnt_w-1:0]       c_last_byte  = c_bcnt_w'(PARM_PAGE_BYTES - 1);
   localparam logic [c_pcnt_w-1:0]       c_last_page  = c_pcnt_w'(c_pages - 1);
   localparam logic [31:0]               c_iter_span  = 32'(c_iter_bytes);
   localparam logic [31:0]               c_page_step  = 32'(PARM_PAGE_BYTES);
   localparam logic [PARM_ERR_WIDTH-1:0] c_err_max    = '1;

   generate
      if (c_pages < 1) begin : g_bad_geometry
         $error("sf_tester_pattern_seq: iteration slice smaller than one page");
      end
   endgenerate

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PAGE_REQ  = 3'd1,
      ST_PAGE_DATA = 3'd2,
      ST_PAGE_WAIT = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic                        r_mode;
   logic [7:0]                  r_pat;
   logic [7:0]                  r_pat_incr;
   logic [c_bcnt_w-1:0]         r_byte_cnt;
   logic [c_pcnt_w-1:0]         r_page_cnt;
   logic [31:0]                 r_page_addr;
   logic [PARM_ERR_WIDTH-1:0]   r_err_count;
   logic                        r_done;
   logic                        r_pass;

   logic                        w_start_evt;
   logic                        w_xfer;
   logic                        w_last_byte;
   logic                        w_last_page;
   logic                        w_mismatch;
   logic [31:0]                 w_base;

   assign w_start_evt = (r_state == ST_IDLE) && i_start;
   // One data beat: a write handshake in generate mode, a read strobe in check mode.
   assign w_xfer      = (r_state == ST_PAGE_DATA) && (r_mode ? i_rd_valid : i_wr_ready);
   assign w_last_byte = (r_byte_cnt == c_last_byte);
   assign w_last_page = (r_page_cnt == c_last_page);
   assign w_mismatch  = w_xfer && r_mode && (i_rd_byte != r_pat);
   assign w_base      = 32'(i_iter_sel) * c_iter_span;

   always_ff @(posedge i_clk_20mhz) begin
      if (i_rst_20mhz) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (i_abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:      if (i_start) w_state_nxt = ST_PAGE_REQ;
            ST_PAGE_REQ:  w_state_nxt = ST_PAGE_DATA;
            ST_PAGE_DATA: if (w_xfer && w_last_byte) w_state_nxt = ST_PAGE_WAIT;
            ST_PAGE_WAIT: if (i_page_done) w_state_nxt = w_last_page ? ST_DONE : ST_PAGE_REQ;
            ST_DONE:      w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk_20mhz) begin
      if (i_rst_20mhz) begin
         r_mode      <= 1'b0;
         r_pat       <= '0;
         r_pat_incr  <= '0;
         r_byte_cnt  <= '0;
         r_page_cnt  <= '0;
         r_page_addr <= '0;
         r_err_count <= '0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_abort) begin
            r_pass <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_start_evt) begin
                     r_mode      <= i_mode;
                     r_pat       <= i_pat_start;
                     r_pat_incr  <= i_pat_incr;
                     r_byte_cnt  <= '0;
                     r_page_cnt  <= '0;
                     r_page_addr <= w_base;
                     r_err_count <= '0;
                     r_pass      <= 1'b0;
                  end
               end
               ST_PAGE_DATA: begin
                  if (w_xfer) begin
                     // Pattern runs continuously across pages of the slice.
                     r_pat      <= r_pat + r_pat_incr;
                     r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + c_bcnt_w'(1);
                     if (w_mismatch && (r_err_count != c_err_max)) begin
                        r_err_count <= r_err_count + PARM_ERR_WIDTH'(1);
                     end
                  end
               end
               ST_PAGE_WAIT: begin
                  if (i_page_done && !w_last_page) begin
                     r_page_addr <= r_page_addr + c_page_step;
                     r_page_cnt  <= r_page_cnt + c_pcnt_w'(1);
                  end
               end
               ST_DONE: begin
                  r_done <= 1'b1;
                  r_pass <= r_mode && (r_err_count == '0);
               end
               default: ;
            endcase
         end
      end
   end

`ifdef SF_TESTER_ERR_ADDR_CAPTURE_EN
   logic [31:0] r_err_addr;

   // A zero error count before this beat marks the first mismatch of the run.
   always_ff @(posedge i_clk_20mhz) begin
      if (i_rst_20mhz) begin
         r_err_addr <= '0;
      end else if (!i_abort) begin
         if (w_start_evt) begin
            r_err_addr <= '0;
         end else if (w_mismatch && (r_err_count == '0)) begin
            r_err_addr <= r_page_addr + 32'(r_byte_cnt);
         end
      end
   end

   assign o_err_addr = r_err_addr;
`else
   assign o_err_addr = '0;
`endif

   assign o_page_req  = (r_state == ST_PAGE_REQ);
   assign o_page_addr = r_page_addr;
   assign o_wr_byte   = r_pat;
   assign o_wr_valid  = (r_state == ST_PAGE_DATA) && !r_mode;
   assign o_busy      = (r_state != ST_IDLE);
   assign o_done      = r_done;
   assign o_pass      = r_pass;
   assign o_err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_sf_tester_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sf_tester_pattern_seq
// Brief    : Self-checking bench for sf_tester_pattern_seq (2 KiB, 4 slices,
//            256-byte pages) plus a 2-bit error counter instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sf_tester_pattern_seq;

   localparam int c_total      = 2048;
   localparam int c_iters      = 4;
   localparam int c_page       = 256;
   localparam int c_iter_bytes = c_total / c_iters;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_start = 1'b0, i_abort = 1'b0, i_mode = 1'b0;
   logic [1:0]  i_iter_sel = '0;
   logic [7:0]  i_pat_start = '0, i_pat_incr = '0, i_rd_byte = '0;
   logic        i_wr_ready = 1'b0, i_rd_valid = 1'b0, i_page_done = 1'b0;

   logic        o_page_req, o_wr_valid, o_busy, o_done, o_pass;
   logic [31:0] o_page_addr, o_err_addr;
   logic [7:0]  o_wr_byte;
   logic [15:0] o_err_count;

   logic        s_page_req, s_wr_valid, s_busy, s_done, s_pass;
   logic [31:0] s_page_addr, s_err_addr;
   logic [7:0]  s_wr_byte;
   logic [1:0]  s_err_count;

   sf_tester_pattern_seq #(
      .PARM_TOTAL_BYTES(c_total), .PARM_ITER_COUNT(c_iters),
      .PARM_PAGE_BYTES(c_page),   .PARM_ERR_WIDTH(16)
   ) u_dut (
      .i_clk_20mhz(clk), .i_rst_20mhz(rst), .i_start(i_start), .i_abort(i_abort),
      .i_mode(i_mode), .i_iter_sel(i_iter_sel), .i_pat_start(i_pat_start),
      .i_pat_incr(i_pat_incr), .o_page_req(o_page_req), .o_page_addr(o_page_addr),
      .o_wr_byte(o_wr_byte), .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready),
      .i_rd_byte(i_rd_byte), .i_rd_valid(i_rd_valid), .i_page_done(i_page_done),
      .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
      .o_err_count(o_err_count), .o_err_addr(o_err_addr)
   );

   sf_tester_pattern_seq #(
      .PARM_TOTAL_BYTES(c_total), .PARM_ITER_COUNT(c_iters),
      .PARM_PAGE_BYTES(c_page),   .PARM_ERR_WIDTH(2)
   ) u_dut_sat (
      .i_clk_20mhz(clk), .i_rst_20mhz(rst), .i_start(i_start), .i_abort(i_abort),
      .i_mode(i_mode), .i_iter_sel(i_iter_sel), .i_pat_start(i_pat_start),
      .i_pat_incr(i_pat_incr), .o_page_req(s_page_req), .o_page_addr(s_page_addr),
      .o_wr_byte(s_wr_byte), .o_wr_valid(s_wr_valid), .i_wr_ready(i_wr_ready),
      .i_rd_byte(i_rd_byte), .i_rd_valid(i_rd_valid), .i_page_done(i_page_done),
      .o_busy(s_busy), .o_done(s_done), .o_pass(s_pass),
      .o_err_count(s_err_count), .o_err_addr(s_err_addr)
   );

   always #25 clk = ~clk;

   int          n_pass  = 0;
   int          n_total = 0;
   logic [7:0]  cap [0:c_iter_bytes-1];
   int          got_err;
   bit          got_pass;
   logic [31:0] got_addr;

   typedef struct {
      bit          mode;
      int          iter;
      logic [7:0]  st;
      logic [7:0]  inc;
      int          rdy;
      int          ca;
      int          cb;
      int          e_err;
      bit          e_pass;
      logic [31:0] e_addr;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [7:0] pat_byte(input logic [7:0] s, input logic [7:0] inc, input int k);
      return 8'(int'(s) + k * int'(inc));
   endfunction

   function automatic logic [31:0] exp_err_addr(input logic [31:0] a);
`ifdef SF_TESTER_ERR_ADDR_CAPTURE_EN
      return a;
`else
      return 32'h0 & a;
`endif
   endfunction

   // Acts as flash controller: grants writes / returns read data, finishes pages.
   task automatic run_seq(input bit mode, input int iter, input logic [7:0] st,
                          input logic [7:0] inc, input int ready_pct, input int ca,
                          input int cb, input int err_pct, input int abort_at, input bit stray);
      logic [31:0] base, mfirst;
      logic [7:0]  good;
      int          k, pb, pg, cyc, wait_cnt, merr, done_cnt;
      bit          data_phase, req_seen, got_done, aborted, strobe, bad;
      base = 32'(iter * c_iter_bytes);
      mfirst = '0;
      k = 0; pb = 0; pg = 0; cyc = 0; wait_cnt = 0; merr = 0;
      data_phase = 0; req_seen = 0; got_done = 0; aborted = 0;
      @(negedge clk);
      i_mode = mode; i_iter_sel = 2'(iter); i_pat_start = st; i_pat_incr = inc; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      while (!got_done && !aborted && cyc < 4000) begin
         i_wr_ready = 0; i_rd_valid = 0; i_page_done = 0; i_start = 0; i_abort = 0;
         if (o_done) begin
            got_done = 1;
         end else begin
            if (o_page_req) begin
               chk("page_req_single", 32'(req_seen), 0);
               chk("page_addr", o_page_addr, base + 32'(pg * c_page));
            end
            if (req_seen) data_phase = 1;
            req_seen = o_page_req;
            if (data_phase) begin
               chk("wr_valid", 32'(o_wr_valid), 32'(!mode));
               if (abort_at >= 0 && k == abort_at) begin
                  i_abort = 1; aborted = 1;
               end else begin
                  strobe = ($urandom_range(99) < ready_pct);
                  if (stray && pg == 0 && pb == 100) begin
                     i_page_done = 1; i_start = 1; i_mode = ~mode;
                     i_iter_sel = ~i_iter_sel; i_pat_start = ~st;
                  end
                  if (!mode) begin
                     i_wr_ready = strobe;
                     if (strobe && o_wr_valid) begin
                        cap[k] = o_wr_byte;
                        chk("wr_byte", o_wr_byte, pat_byte(st, inc, k));
                        k++; pb++;
                     end
                  end else if (strobe) begin
                     good = pat_byte(st, inc, k);
                     bad  = (k == ca) || (k == cb) || ($urandom_range(99) < err_pct);
                     i_rd_valid = 1;
                     i_rd_byte  = bad ? (good ^ 8'($urandom_range(255, 1))) : good;
                     if (bad) begin
                        if (merr == 0) mfirst = base + 32'(k);
                        merr++;
                     end
                     k++; pb++;
                  end
                  if (pb == c_page) begin
                     data_phase = 0; pb = 0; pg++; wait_cnt = $urandom_range(4, 1);
                  end
               end
            end else if (wait_cnt > 0) begin
               wait_cnt--;
               if (wait_cnt == 0) i_page_done = 1;
            end
         end
         if (!got_done && !aborted) begin
            @(negedge clk);
            cyc++;
         end
      end
      if (aborted) begin
         @(negedge clk);
         i_abort = 0;
         done_cnt = 0;
         chk("abort_busy", 32'(o_busy), 0);
         chk("abort_pass", 32'(o_pass), 0);
         for (int i = 0; i < 8; i++) begin
            if (o_done) done_cnt++;
            @(negedge clk);
         end
         chk("abort_no_done", done_cnt, 0);
      end else begin
         chk("run_done", 32'(got_done), 1);
         chk("run_bytes", k, c_iter_bytes);
         chk("err_count", 32'(o_err_count), merr);
         chk("pass", 32'(o_pass), 32'(mode && merr == 0));
         chk("err_addr", o_err_addr, exp_err_addr(mfirst));
         chk("sat_err_count", 32'(s_err_count), (merr > 3) ? 3 : merr);
         chk("sat_pass", 32'(s_pass), 32'(mode && merr == 0));
         got_err = int'(o_err_count); got_pass = o_pass; got_addr = o_err_addr;
         if (!got_done) begin
            i_abort = 1; @(negedge clk); i_abort = 0;
         end
         @(negedge clk);
         chk("done_pulse_len", 32'(o_done), 0);
         chk("idle_busy", 32'(o_busy), 0);
      end
   endtask

   initial begin
      vec_t vecs [7];
      int   done_cnt;
      bit   rmode;
      vecs[0] = '{1'b0, 1, 8'h08, 8'h07, 100, -1,  -1,    0, 1'b0, 32'h000};
      vecs[1] = '{1'b0, 1, 8'h08, 8'h07,  50, -1,  -1,    0, 1'b0, 32'h000};
      vecs[2] = '{1'b1, 0, 8'h00, 8'h01, 100, -1,  -1,    0, 1'b1, 32'h000};
      vecs[3] = '{1'b1, 0, 8'h00, 8'h01,  70,  5,  'h1FF, 2, 1'b0, 32'h005};
      vecs[4] = '{1'b1, 3, 8'hA5, 8'h03,  60,  0,  -1,    1, 1'b0, 32'h600};
      vecs[5] = '{1'b1, 2, 8'hFF, 8'hFF,  80, 'h100, 'h0FF, 2, 1'b0, 32'h4FF};
      vecs[6] = '{1'b0, 2, 8'h00, 8'h00, 100, -1,  -1,    0, 1'b0, 32'h000};

      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_page_req", 32'(o_page_req), 0);
      chk("rst_wr_valid", 32'(o_wr_valid), 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_done", 32'(o_done), 0);
      chk("rst_pass", 32'(o_pass), 0);
      chk("rst_err_count", 32'(o_err_count), 0);
      chk("rst_err_addr", o_err_addr, 0);
      chk("rst_page_addr", o_page_addr, 0);
      chk("rst_wr_byte", 32'(o_wr_byte), 0);

      for (int i = 0; i < 7; i++) begin
         run_seq(vecs[i].mode, vecs[i].iter, vecs[i].st, vecs[i].inc, vecs[i].rdy,
                 vecs[i].ca, vecs[i].cb, 0, -1, 1'b0);
         chk("vec_err_count", 32'(got_err), 32'(vecs[i].e_err));
         chk("vec_pass", 32'(got_pass), 32'(vecs[i].e_pass));
         chk("vec_err_addr", got_addr, exp_err_addr(vecs[i].e_addr));
         if (i < 2) begin
            chk("gen_byte1", 32'(cap[1]), 32'h0F);
            chk("gen_byte2", 32'(cap[2]), 32'h16);
            chk("gen_byte256", 32'(cap[256]), 32'h08);
            chk("gen_byte511", 32'(cap[511]), 32'h01);
         end
      end

      // Abort during page two of an erroring run, then a clean restart.
      run_seq(1'b1, 1, 8'h10, 8'h01, 100, 3, -1, 0, 300, 1'b0);
      run_seq(1'b1, 1, 8'h10, 8'h01, 100, -1, -1, 0, -1, 1'b0);
      chk("restart_err_count", 32'(got_err), 0);
      chk("restart_pass", 32'(got_pass), 1);

      // Start and page_done while streaming must not disturb the sequence.
      run_seq(1'b0, 0, 8'h33, 8'h05, 80, -1, -1, 0, -1, 1'b1);
      run_seq(1'b1, 3, 8'h5A, 8'h11, 90, 7, -1, 0, -1, 1'b1);

      // Reset in the middle of a generate run.
      @(negedge clk);
      i_mode = 1'b0; i_iter_sel = 2'd2; i_pat_start = 8'h44; i_pat_incr = 8'h01; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0; i_wr_ready = 1'b1;
      repeat (40) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; i_wr_ready = 1'b0;
      chk("midrst_busy", 32'(o_busy), 0);
      chk("midrst_wr_valid", 32'(o_wr_valid), 0);
      chk("midrst_page_addr", o_page_addr, 0);
      chk("midrst_wr_byte", 32'(o_wr_byte), 0);
      done_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         i_page_done = (i % 3 == 0);
         if (o_done) done_cnt++;
         @(negedge clk);
      end
      i_page_done = 1'b0;
      chk("midrst_no_done", done_cnt, 0);

      for (int r = 0; r < 8; r++) begin
         rmode = 1'($urandom_range(1));
         run_seq(rmode, int'($urandom_range(3)), 8'($urandom), 8'($urandom),
                 int'($urandom_range(100, 30)), -1, -1, int'($urandom_range(3)), -1, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
